// File: rtl/beef_pkg.sv
// Shared opcode and state encodings for the BeeF execution core.
package beef_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_INC   = 4'h1,
        OP_DEC   = 4'h2,
        OP_RIGHT = 4'h3,
        OP_LEFT  = 4'h4,
        OP_LOOP  = 4'h5,
        OP_END   = 4'h6,
        OP_OUT   = 4'h7,
        OP_IN    = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SKIP,
        S_WAIT_OUT,
        S_WAIT_IN,
        S_HALT,
        S_ERROR
    } state_t;

endpackage

// File: rtl/beef_loop_stack.sv
// LIFO of loop-body start addresses; top is readable combinationally.
module beef_loop_stack
    import beef_pkg::*;
#(
    parameter int PAW        = 8,
    parameter int LOOP_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic           clear,
    input  logic [PAW-1:0] push_data,
    output logic [PAW-1:0] top,
    output logic           full,
    output logic           empty
);

    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    localparam int IXW = $clog2(LOOP_DEPTH);

    logic [PAW-1:0] mem [LOOP_DEPTH];
    logic [SPW-1:0] sp;
    logic [IXW-1:0] top_idx;
    logic [IXW-1:0] wr_idx;

    assign top_idx = IXW'(sp - 1'b1);
    assign wr_idx  = IXW'(sp);
    assign top     = mem[top_idx];
    assign full    = (sp == SPW'(LOOP_DEPTH));
    assign empty   = (sp == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/beef_core.sv
// Multi-cycle BeeF execution core with hardware loop stack and byte I/O.
// Define BEEF_IO_EN to implement the '.'/',' handshake states.
module beef_core
    import beef_pkg::*;
#(
    parameter int DW         = 8,
    parameter int DAW        = 8,
    parameter int PAW        = 8,
    parameter int IW         = 9,
    parameter int LOOP_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic [PAW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    output logic [DAW-1:0] dmem_addr,
    input  logic [DW-1:0]  dmem_rdata,
    output logic [DW-1:0]  dmem_wdata,
    output logic           dmem_we,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    input  logic           out_ready,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t         state;
    logic [PAW-1:0] pc;
    logic [PAW-1:0] pc_inc;
    logic [DAW-1:0] ptr;
    logic [PAW-1:0] depth;
    opcode_t        opc;
    logic           cell_nz;
    logic           stk_push, stk_pop, stk_clear;
    logic [PAW-1:0] stk_top;
    logic           stk_full, stk_empty;
    logic           unused_bits;

    assign opc       = opcode_t'(imem_data[OPC_W-1:0]);
    assign cell_nz   = |dmem_rdata;
    assign pc_inc    = pc + 1'b1;
    assign imem_addr = pc;
    assign dmem_addr = ptr;
    assign out_data  = dmem_rdata;
    assign busy      = (state == S_RUN) || (state == S_SKIP) ||
                       (state == S_WAIT_OUT) || (state == S_WAIT_IN);
    assign done      = (state == S_HALT);
    assign err       = (state == S_ERROR);

`ifdef BEEF_IO_EN
    assign out_valid   = (state == S_WAIT_OUT);
    assign in_ready    = (state == S_WAIT_IN);
    assign unused_bits = ^imem_data[IW-1:OPC_W];
`else
    assign out_valid   = 1'b0;
    assign in_ready    = 1'b0;
    assign unused_bits = ^{imem_data[IW-1:OPC_W], out_ready, in_valid, in_data};
`endif

    beef_loop_stack #(
        .PAW        (PAW),
        .LOOP_DEPTH (LOOP_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Data-memory writes and stack commands are decoded from the current instruction
    always_comb begin
        dmem_we    = 1'b0;
        dmem_wdata = dmem_rdata;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;
        case (state)
            S_IDLE, S_HALT, S_ERROR: stk_clear = start;
            S_RUN: begin
                case (opc)
                    OP_INC: begin
                        dmem_we    = 1'b1;
                        dmem_wdata = dmem_rdata + 1'b1;
                    end
                    OP_DEC: begin
                        dmem_we    = 1'b1;
                        dmem_wdata = dmem_rdata - 1'b1;
                    end
                    OP_LOOP: stk_push = cell_nz && !stk_full;
                    OP_END:  stk_pop  = !cell_nz && !stk_empty;
                    default: ;
                endcase
            end
`ifdef BEEF_IO_EN
            S_WAIT_IN: begin
                if (in_valid) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = in_data;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ptr   <= '0;
            depth <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start) begin
                        state <= S_RUN;
                        pc    <= '0;
                        ptr   <= '0;
                        depth <= '0;
                    end
                end
                S_RUN: begin
                    case (opc)
                        OP_RIGHT: begin
                            ptr <= ptr + 1'b1;
                            pc  <= pc_inc;
                        end
                        OP_LEFT: begin
                            ptr <= ptr - 1'b1;
                            pc  <= pc_inc;
                        end
                        OP_LOOP: begin
                            if (!cell_nz) begin
                                state <= S_SKIP;
                                depth <= '0;
                                pc    <= pc_inc;
                            end else if (stk_full) begin
                                state <= S_ERROR;
                            end else begin
                                pc <= pc_inc;
                            end
                        end
                        OP_END: begin
                            if (stk_empty)    state <= S_ERROR;
                            else if (cell_nz) pc    <= stk_top;
                            else              pc    <= pc_inc;
                        end
`ifdef BEEF_IO_EN
                        OP_OUT:  state <= S_WAIT_OUT;
                        OP_IN:   state <= S_WAIT_IN;
`endif
                        OP_HALT: state <= S_HALT;
                        default: pc    <= pc_inc;
                    endcase
                end
                S_SKIP: begin
                    if (opc == OP_END && depth == '0) begin
                        pc    <= pc_inc;
                        state <= S_RUN;
                    end else if (pc == '1) begin
                        state <= S_ERROR;
                    end else begin
                        pc <= pc_inc;
                        if (opc == OP_LOOP)     depth <= depth + 1'b1;
                        else if (opc == OP_END) depth <= depth - 1'b1;
                    end
                end
`ifdef BEEF_IO_EN
                S_WAIT_OUT: begin
                    if (out_ready) begin
                        pc    <= pc_inc;
                        state <= S_RUN;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        pc    <= pc_inc;
                        state <= S_RUN;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beef_core.sv
// Scoreboard bench for beef_core: output bytes checked by a monitor, status/tape checked directly.
module tb_beef_core;

    localparam int DW = 8, DAW = 8, PAW = 8, IW = 9, LOOP_DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [PAW-1:0] imem_addr;
    logic [IW-1:0]  imem_data;
    logic [DAW-1:0] dmem_addr;
    logic [DW-1:0]  dmem_rdata;
    logic [DW-1:0]  dmem_wdata;
    logic           dmem_we;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           busy, done, err;

    logic [IW-1:0]  prog [256];
    logic [DW-1:0]  tape [256];
    logic           tape_clr = 1'b0;
    logic [DW-1:0]  exp_q [$];
    int             n_tests = 0;
    int             n_fail = 0;
    int             we_cnt = 0;
    int             cyc;
    int             we_before;

    always #5 clk = ~clk;

    assign imem_data  = prog[imem_addr];
    assign dmem_rdata = tape[dmem_addr];

    always @(posedge clk) begin
        if (tape_clr) begin
            for (int i = 0; i < 256; i++) tape[i] <= '0;
        end else if (dmem_we) begin
            tape[dmem_addr] <= dmem_wdata;
        end
    end

    beef_core #(
        .DW(DW), .DAW(DAW), .PAW(PAW), .IW(IW), .LOOP_DEPTH(LOOP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .done(done), .err(err)
    );

    // Monitor: every accepted output byte is matched against the scoreboard queue
    always @(negedge clk) begin
        if (reset && dmem_we) we_cnt <= we_cnt + 1;
        if (reset && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_byte: got %0h, none expected", out_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL out_byte: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 256; i++) prog[i] = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+": prog[i] = 9'h1;
                "-": prog[i] = 9'h2;
                ">": prog[i] = 9'h3;
                "<": prog[i] = 9'h4;
                "[": prog[i] = 9'h5;
                "]": prog[i] = 9'h6;
                ".": prog[i] = 9'h7;
                ",": prog[i] = 9'h8;
                default: prog[i] = 9'h0;
            endcase
        end
        prog[s.len()] = 9'h1F;
    endtask

    // Clears the tape, then pulses start so that the last edge seen is the start edge
    task automatic do_start();
        @(negedge clk) tape_clr = 1'b1;
        @(negedge clk) begin tape_clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(output int c);
        c = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            c++;
            if (done || err) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_end: timeout, done=%0b err=%0b", done, err);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", dmem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        @(negedge clk) reset = 1'b1;

        // +++>++. with output always accepted
        load("+++>++.");
        out_ready = 1'b1;
`ifdef BEEF_IO_EN
        exp_q.push_back(8'd2);
`endif
        do_start();
        wait_end(cyc);
`ifdef BEEF_IO_EN
        check("t1_cycles", cyc, 9);
`else
        check("t1_cycles", cyc, 8);
`endif
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_cell0", tape[0], 3);
        check("t1_cell1", tape[1], 2);
        check("t1_ptr", dmem_addr, 1);
        repeat (3) @(posedge clk);
        #1 check("t1_done_sticky", done, 1);

        // ++[->+<] : one taken END back to PC 3
        load("++[->+<]");
        do_start();
        wait_end(cyc);
        check("t2_cycles", cyc, 14);
        check("t2_cell0", tape[0], 0);
        check("t2_cell1", tape[1], 2);
        check("t2_halt_pc", imem_addr, 8);
        check("t2_done", done, 1);

        // [[+]+] on a zero cell is skipped without touching memory
        load("[[+]+]");
        do_start();
        we_before = we_cnt;
        wait_end(cyc);
        check("t3_cycles", cyc, 7);
        check("t3_halt_pc", imem_addr, 6);
        check("t3_no_writes", we_cnt - we_before, 0);
        check("t3_cell0", tape[0], 0);

        // pointer and cell wrap
        load("<-");
        do_start();
        wait_end(cyc);
        check("t4_cycles", cyc, 3);
        check("t4_ptr_wrap", dmem_addr, 255);
        check("t4_cell_wrap", tape[255], 8'hFF);

        // END on an empty stack
        load("+]");
        do_start();
        wait_end(cyc);
        check("t5_err", err, 1);
        check("t5_cycles", cyc, 2);

        // LOOP_DEPTH+1 nested opens overflow the stack; restart clears it
        load("+[[[[[[[[[");
        do_start();
        wait_end(cyc);
        check("t6_err", err, 1);
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_cycles", cyc, 10);
        repeat (2) @(posedge clk);
        #1 check("t6_err_sticky", err, 1);
        do_start();
        check("t6_restart_err", err, 0);
        check("t6_restart_pc", imem_addr, 0);
        check("t6_restart_busy", busy, 1);
        wait_end(cyc);
        check("t6_rerun_cycles", cyc, 10);

        // ',' with a delayed producer
        load(",");
        do_start();
`ifdef BEEF_IO_EN
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t7_in_ready_wait", in_ready, 1);
            check("t7_busy_wait", busy, 1);
        end
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("t7_cell0", tape[0], 8'hA5);
        check("t7_in_ready_after", in_ready, 0);
        in_valid = 1'b0;
        wait_end(cyc);
        check("t7_done", done, 1);
`else
        wait_end(cyc);
        check("t7_cycles", cyc, 2);
        check("t7_in_ready", in_ready, 0);
        check("t7_cell0", tape[0], 0);
`endif

        // reset asserted while an output is pending
        load(".");
        out_ready = 1'b0;
        do_start();
        @(posedge clk);
        #2;
`ifdef BEEF_IO_EN
        check("t8_out_valid", out_valid, 1);
        check("t8_out_data", out_data, 0);
`endif
        check("t8_busy_pre", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("t8_out_valid_rst", out_valid, 0);
        check("t8_busy_rst", busy, 0);
        check("t8_done_rst", done, 0);
        check("t8_pc_rst", imem_addr, 0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t8_idle_busy", busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
